// File: rtl/angular_filter_acc_if.sv
// Tap-product / filtered-sample handshake bundle for the angular filter accumulator.
// The slave side is the accumulator; the master side feeds taps and drains samples.
interface angular_filter_acc_if #(
  parameter int BIT_DEPTH = 8,
  parameter int PROD_W    = 16,
  parameter int CNT_W     = 11
);
  logic                 cfg_start;
  logic [CNT_W-1:0]     cfg_count;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [PROD_W-1:0]    in_p0;
  logic [PROD_W-1:0]    in_p1;
  logic [PROD_W-1:0]    in_p2;
  logic [PROD_W-1:0]    in_p3;
  logic [3:0]           in_neg;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_DEPTH-1:0] out_sample;
  logic                 out_last;

  modport slave (
    input  cfg_start, cfg_count, in_valid, in_p0, in_p1, in_p2, in_p3, in_neg, out_ready,
    output busy, in_ready, out_valid, out_sample, out_last
  );

  modport master (
    output cfg_start, cfg_count, in_valid, in_p0, in_p1, in_p2, in_p3, in_neg, out_ready,
    input  busy, in_ready, out_valid, out_sample, out_last
  );
endinterface

// File: rtl/angular_filter_acc.sv
// Sums four signed tap products, rounds, shifts and clips to BIT_DEPTH; 2-cycle latency,
// 1 sample/cycle; elastic valid/ready with 2-deep buffering, in_ready drops when both stages are full.
module angular_filter_acc #(
  parameter int BIT_DEPTH = 8,
  parameter int PROD_W    = 16,
  parameter int SHIFT     = 6,
  parameter int CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  angular_filter_acc_if.slave  bus
);
  localparam int A_W   = PROD_W + 2;
  localparam int SUM_W = PROD_W + 3;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1 << (SHIFT - 1));

  logic                  busy_q;
  logic                  last_taken;
  logic [CNT_W-1:0]      remaining;
  logic                  s1_valid;
  logic                  s1_last;
  logic signed [A_W-1:0] s1_a;
  logic signed [A_W-1:0] s1_b;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [BIT_DEPTH-1:0]  out_sample_q;

  logic                  cfg_accept;
  logic                  in_accept;
  logic                  s1_advance;
  logic                  out_take;
  logic                  in_ready_c;

  logic [PROD_W-1:0]     prod [4];
  logic signed [PROD_W:0] tap [4];
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic [BIT_DEPTH-1:0]  clipped;

  assign prod[0] = bus.in_p0;
  assign prod[1] = bus.in_p1;
  assign prod[2] = bus.in_p2;
  assign prod[3] = bus.in_p3;

  assign out_take   = out_valid_q & bus.out_ready;
  assign s1_advance = s1_valid & (~out_valid_q | bus.out_ready);
  assign in_ready_c = busy_q & ~last_taken & (~s1_valid | s1_advance);
  assign in_accept  = bus.in_valid & in_ready_c;
  assign cfg_accept = bus.cfg_start & ~busy_q & (bus.cfg_count != '0);

  assign bus.busy       = busy_q;
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_last   = out_last_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tap[i] = bus.in_neg[i] ? -$signed({1'b0, prod[i]}) : $signed({1'b0, prod[i]});
    end
  end

  // Sign bit catches negatives; any set bit above the sample width means overflow.
  always_comb begin
    sum     = SUM_W'(s1_a) + SUM_W'(s1_b) + RND;
    shifted = sum >>> SHIFT;
    if (shifted[SUM_W-1]) begin
      clipped = '0;
    end else if (|shifted[SUM_W-2:BIT_DEPTH]) begin
      clipped = '1;
    end else begin
      clipped = shifted[BIT_DEPTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      last_taken <= 1'b0;
      remaining  <= '0;
    end else begin
      if (cfg_accept) begin
        busy_q     <= 1'b1;
        last_taken <= 1'b0;
        remaining  <= bus.cfg_count;
      end else begin
        if (out_take && out_last_q) begin
          busy_q <= 1'b0;
        end
        if (in_accept) begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            last_taken <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_accept) begin
      s1_valid <= 1'b1;
      s1_last  <= (remaining == CNT_W'(1));
      s1_a     <= A_W'(tap[0]) + A_W'(tap[1]);
      s1_b     <= A_W'(tap[2]) + A_W'(tap[3]);
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_last_q   <= 1'b0;
    end else if (s1_advance) begin
      out_valid_q  <= 1'b1;
      out_sample_q <= clipped;
      out_last_q   <= s1_last;
    end else if (out_take) begin
      out_valid_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_angular_filter_acc.sv
// Directed + randomized bench for angular_filter_acc against a queue-based sample/occupancy model.
module tb_angular_filter_acc;
  localparam int BD = 8;
  localparam int PW = 16;
  localparam int SH = 6;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  angular_filter_acc_if #(.BIT_DEPTH(BD), .PROD_W(PW), .CNT_W(CW)) bus ();

  angular_filter_acc #(.BIT_DEPTH(BD), .PROD_W(PW), .SHIFT(SH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int sample;
    bit last;
  } exp_t;

  exp_t expq[$];
  bit   m_busy;
  int   m_rem;
  bit   stalled;
  int   held_sample;
  bit   held_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sample(input int p0, input int p1, input int p2, input int p3,
                                    input logic [3:0] neg);
    int p[4];
    int s;
    int maxv;
    p    = '{p0, p1, p2, p3};
    maxv = (1 << BD) - 1;
    s    = 1 << (SH - 1);
    for (int i = 0; i < 4; i++) s += neg[i] ? -p[i] : p[i];
    s = (s >= 0) ? s / (1 << SH) : -((-s + (1 << SH) - 1) / (1 << SH));
    if (s < 0) return 0;
    if (s > maxv) return maxv;
    return s;
  endfunction

  // Observer: checks busy/in_ready against occupancy, output order, tags and stall stability.
  always @(negedge clk) begin
    bit   cfg_ok;
    bit   exp_rdy;
    bit   popped_last;
    exp_t e;
    if (!rst_n) begin
      expq.delete();
      m_busy  = 1'b0;
      m_rem   = 0;
      stalled = 1'b0;
    end else begin
      cfg_ok  = bus.cfg_start && !m_busy && (bus.cfg_count != 0);
      exp_rdy = m_busy && (m_rem != 0) && (expq.size() < 2 || bus.out_ready);
      check("busy", bus.busy, m_busy);
      check("in_ready", bus.in_ready, exp_rdy);
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_sample", bus.out_sample, held_sample);
        check("stall_last", bus.out_last, held_last);
      end
      popped_last = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 0);
        end else begin
          e = expq.pop_front();
          check("out_sample", bus.out_sample, e.sample);
          check("out_last", bus.out_last, e.last);
          popped_last = e.last;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.sample = ref_sample(bus.in_p0, bus.in_p1, bus.in_p2, bus.in_p3, bus.in_neg);
        e.last   = (m_rem == 1);
        m_rem--;
        expq.push_back(e);
      end
      if (popped_last) m_busy = 1'b0;
      if (cfg_ok) begin
        m_busy = 1'b1;
        m_rem  = bus.cfg_count;
      end
      stalled     = bus.out_valid && !bus.out_ready;
      held_sample = bus.out_sample;
      held_last   = bus.out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int n);
    bus.cfg_count = CW'(n);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic set_data(input int p0, input int p1, input int p2, input int p3,
                          input logic [3:0] neg);
    bus.in_p0  = PW'(p0);
    bus.in_p1  = PW'(p1);
    bus.in_p2  = PW'(p2);
    bus.in_p3  = PW'(p3);
    bus.in_neg = neg;
  endtask

  task automatic rand_data();
    set_data($urandom_range(0, 16320), $urandom_range(0, 16320), $urandom_range(0, 16320),
             $urandom_range(0, 16320), 4'($urandom));
  endtask

  task automatic send_one(input int p0, input int p1, input int p2, input int p3,
                          input logic [3:0] neg);
    bit acc = 1'b0;
    set_data(p0, p1, p2, p3, neg);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", bus.in_ready, 1);
  endtask

  task automatic wait_idle();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 300 && bus.busy; k++) tick();
    check("block_end_busy", bus.busy, 0);
  endtask

  // mode 0: out_ready high; 1: random gaps on both sides; 2: out_ready low for first 5 cycles.
  task automatic run_block(input int n, input int mode);
    int cnt = 0;
    int cyc = 0;
    bit acc;
    start_block(n);
    rand_data();
    bus.in_valid = (mode != 1) || ($urandom_range(0, 3) != 0);
    while (cnt < n && cyc < 500) begin
      bus.out_ready = (mode == 2) ? (cyc >= 5) : (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (mode == 2 && cyc == 4) begin
        check("bp_accepts_before_release", cnt, 2);
        check("bp_in_ready_full", bus.in_ready, 0);
      end
      tick();
      if (acc) cnt++;
      if (acc || !bus.in_valid) rand_data();
      bus.in_valid = (cnt < n) && ((mode != 1) || ($urandom_range(0, 3) != 0));
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (cnt < n) check("run_accept_timeout", cnt, n);
    for (int k = 0; k < 300 && bus.busy; k++) begin
      bus.out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (mode == 2) check("bp_in_ready_after_last", bus.in_ready, 0);
      tick();
    end
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_count = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_data(0, 0, 0, 0, 4'h0);
    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single tap with exact timing; cfg_start in the final handshake cycle must be ignored.
    start_block(1);
    send_one(6400, 0, 0, 0, 4'h0);
    check("single_s1_out_valid", bus.out_valid, 0);
    tick();
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_sample", bus.out_sample, 100);
    check("single_out_last", bus.out_last, 1);
    check("single_busy_during_hs", bus.busy, 1);
    bus.cfg_count = CW'(2);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("single_busy_after_hs", bus.busy, 0);
    check("single_out_valid_after_hs", bus.out_valid, 0);
    tick();
    check("cfg_in_hs_ignored", bus.busy, 0);

    // Mixed sign and both clip rails.
    start_block(3);
    send_one(100, 11600, 2000, 0, 4'b0001);
    send_one(0, 16320, 16320, 0, 4'b0000);
    send_one(16320, 0, 0, 0, 4'b0001);
    wait_idle();

    run_block(4, 2);

    // cfg_start while busy is ignored; the block still ends after 3.
    start_block(3);
    rand_data();
    send_one(bus.in_p0, bus.in_p1, bus.in_p2, bus.in_p3, bus.in_neg);
    start_block(5);
    repeat (2) begin
      rand_data();
      send_one(bus.in_p0, bus.in_p1, bus.in_p2, bus.in_p3, bus.in_neg);
    end
    wait_idle();
    check("busy_guard_in_ready", bus.in_ready, 0);

    start_block(0);
    repeat (2) tick();
    check("zero_count_busy", bus.busy, 0);
    check("zero_count_in_ready", bus.in_ready, 0);

    repeat (20) run_block($urandom_range(1, 6), $urandom_range(0, 1));

    // Reset with two samples in flight.
    bus.out_ready = 1'b0;
    start_block(8);
    repeat (2) begin
      rand_data();
      send_one(bus.in_p0, bus.in_p1, bus.in_p2, bus.in_p3, bus.in_neg);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_last", bus.out_last, 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_idle", bus.busy, 0);
    run_block(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/angular_filter_acc.md
Name: angular_filter_acc

Overview:
- Downstream consumer of the constant-multiplier bank in the VVC intra angular datapath.
- Per predicted sample, receives four tap products (reference sample × filter coefficient), already selected by the coefficient mux, each with a sign flag.
- Sums the four taps, rounds, shifts and clips to the sample bit depth.
- Two-stage elastic valid/ready pipeline with a per-block sample counter that tags the final sample of a prediction block.

Parameters:
- BIT_DEPTH, 8, output sample width; clip range 0..2^BIT_DEPTH-1
- PROD_W, 16, width of each tap product input (unsigned magnitude)
- SHIFT, 6, normalisation shift; rounding offset = 1<<(SHIFT-1)
- CNT_W, 11, width of block sample count

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; loads cfg_count and opens a block
- cfg_count  in  CNT_W  samples in block (1..2^CNT_W-1)
- busy  out  1  block open: from accepted cfg_start until last output handshake
- in_valid  in  1  tap products valid
- in_ready  out  1  stage accepts input
- in_p0..in_p3  in  PROD_W each  tap product magnitudes
- in_neg  in  4  bit i set: tap i subtracted
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_sample  out  BIT_DEPTH  filtered, clipped sample
- out_last  out  1  marks final sample of block

Behaviour:
- Reset (async, rst_n=0): busy=0, out_valid=0, out_sample=0, out_last=0, all stage valid bits 0, sample counter 0. in_ready=0 while busy=0.
- Config:
  - cfg_start is accepted only when busy=0 and cfg_count!=0; it sets busy=1 and loads remaining=cfg_count.
  - cfg_start while busy=1, or with cfg_count=0, is ignored with no state change.
- Input acceptance:
  - in_ready = busy & ~last_taken & (~s1_valid | s1_advance).
  - last_taken sets when the input carrying last is accepted.
  - Each accepted input decrements remaining. The input accepted with remaining==1 is tagged last.
  - Once last is taken, in_ready=0 until the next block opens.
- Stage 1 (register on accept):
  - t_i = in_neg[i] ? -p_i : +p_i, with p_i zero-extended to PROD_W+1 signed.
  - Stores s_a = t0+t1 and s_b = t2+t3 at PROD_W+2 bits, plus the last tag.
- Stage 2:
  - sum = s_a + s_b + (1<<(SHIFT-1)) at PROD_W+3 bits signed.
  - r = sum >>> SHIFT (arithmetic; floor for negatives).
  - Clip: r<0 → 0; r>2^BIT_DEPTH-1 → 2^BIT_DEPTH-1; else r.
  - Registers out_sample and out_last.
- Elastic flow:
  - A stage advances when its downstream register is empty or is being consumed the same cycle.
  - s2 consumed = out_valid & out_ready. s1_advance = s1_valid & (~out_valid | out_ready).
  - Latency is 2 cycles from input handshake to out_valid with out_ready held 1. Throughput is 1 sample/cycle.
  - The out_ready→in_ready combinational path is permitted.
- Stall: while out_valid=1 and out_ready=0, out_sample and out_last hold stable. At most 2 samples are buffered (s1 + s2); in_ready drops when both are full.
- Block end: busy clears in the cycle after the out_last handshake. cfg_start in that same handshake cycle is ignored, since busy is still 1.
- Simultaneous events: accept into s1 and advance s1→s2 in the same cycle is legal and loses no data. Order is strictly preserved.
- Reset mid-block: all in-flight samples are discarded, busy=0, and no out_last is emitted.
- Sign inputs are ignored when in_valid=0. Products are treated as magnitudes; the maximum legal product is 64×(2^BIT_DEPTH-1).

Test Plan:
- Single tap: cfg_count=1; p0=6400, others 0, in_neg=0 → out_sample=100, out_last=1 two cycles after accept; busy falls one cycle after the out handshake.
- Mixed sign: p0=100 (neg), p1=11600, p2=2000, p3=0 → sum 13532 → out_sample=211.
- Clip high/low:
  - p1=p2=16320 → 510 → out_sample=255.
  - p0=16320 neg, others 0 → -255 → out_sample=0.
- Backpressure: cfg_count=4, stream 4 samples, out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - After out_ready=1, all 4 outputs emerge in order with no loss or duplication.
  - out_last is set only on the 4th; in_ready stays 0 after the 4th accept.
- Config guards:
  - cfg_start while busy → ignored; the block still ends after the original count.
  - cfg_start with cfg_count=0 → busy stays 0, in_ready stays 0.
- Reset mid-block: rst_n low after 2 of 8 samples accepted → out_valid=0, busy=0 immediately. A new block of 1 then completes normally.
